// File: rtl/mage_pkg.sv
// Shared constants and types for the load/store stream-select configuration
// block: word counts, address-map bases and the commit FSM state encoding.
package mage_pkg;

    localparam int N_CFG_REGS_32_SEL_L_STREAM = 4;
    localparam int N_CFG_REGS_32_SEL_S_STREAM = 2;

    // Word-address bases of the two shadow banks.
    localparam int CFG_LS_SEL_L_BASE = 0;
    localparam int CFG_LS_SEL_S_BASE = N_CFG_REGS_32_SEL_L_STREAM;

    localparam int CFG_WORD_W     = 32;
    localparam int CFG_WORD_BYTES = CFG_WORD_W / 8;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } cfg_commit_state_e;

endpackage

// File: rtl/cfg_shadow_word.sv
// One 32-bit shadow/active configuration pair. The host writes the shadow
// with byte enables; a copy strobe transfers the whole shadow into active.
module cfg_shadow_word
    import mage_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      wr_en_i,
    input  logic [CFG_WORD_BYTES-1:0] be_i,
    input  logic [CFG_WORD_W-1:0]     wdata_i,
    input  logic                      copy_i,
    output logic [CFG_WORD_W-1:0]     shadow_o,
    output logic [CFG_WORD_W-1:0]     active_o
);

    // Byte-enabled shadow update; unselected bytes hold.
    // NOTE: the shadow is a small register bank, not a RAM, so it is reset
    // like any other state and a reset never exposes stale configuration.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shadow_o <= '0;
        end else if (wr_en_i) begin
            for (int b = 0; b < CFG_WORD_BYTES; b++) begin
                if (be_i[b]) begin
                    shadow_o[b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Atomic copy of the shadow into the active word.
    // NOTE: non-blocking assignment means the copy takes the shadow value
    // from before this edge, so a same-cycle write waits for the next commit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            active_o <= '0;
        end else if (copy_i) begin
            active_o <= shadow_o;
        end
    end

endmodule

// File: rtl/cfg_regs_ls_stream_sel_wr.sv
// Host-writable shadow bank for the load/store stream-select words with an
// atomic, busy-aware commit into the active registers driving the crossbars.
// Optional feature: define CFG_LS_SEL_READBACK_EN to build the shadow readback
// mux; without it in-range reads return 0 with no error.
module cfg_regs_ls_stream_sel_wr
    import mage_pkg::*;
#(
    parameter int N_L_REGS = N_CFG_REGS_32_SEL_L_STREAM,
    parameter int N_S_REGS = N_CFG_REGS_32_SEL_S_STREAM,
    parameter int ADDR_W   = ($clog2(N_L_REGS + N_S_REGS) > 1) ?
                             $clog2(N_L_REGS + N_S_REGS) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [31:0]              wdata_i,
    input  logic [3:0]               be_i,
    output logic                     gnt_o,
    output logic                     rvalid_o,
    output logic [31:0]              rdata_o,
    output logic                     err_o,
    input  logic                     commit_i,
    input  logic                     busy_i,
    output logic                     commit_pending_o,
    output logic                     commit_done_o,
    output logic [N_L_REGS*32-1:0]   reg_cfg_l_stream_sel_o,
    output logic [N_S_REGS*32-1:0]   reg_cfg_s_stream_sel_o
);

    localparam int N_WORDS = N_L_REGS + N_S_REGS;

    logic [N_WORDS-1:0]       word_we;
    logic [N_WORDS-1:0][31:0] shadow_q;
    logic [N_WORDS-1:0][31:0] active_q;
    logic                     in_range;
    logic                     copy_en;
    logic [31:0]              rd_word;
    cfg_commit_state_e        state_q;

    assign gnt_o    = req_i;
    assign in_range = (32'(addr_i) < 32'(N_WORDS));

    // The copy fires on an idle commit with the PEA stopped, or as soon as a
    // pending commit sees busy low.
    assign copy_en = !busy_i &&
                     ((state_q == IDLE && commit_i) || state_q == PENDING);

    for (genvar w = 0; w < N_WORDS; w++) begin : g_word
        assign word_we[w] = req_i & we_i & (addr_i == ADDR_W'(w));

        cfg_shadow_word u_word (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .wr_en_i  (word_we[w]),
            .be_i     (be_i),
            .wdata_i  (wdata_i),
            .copy_i   (copy_en),
            .shadow_o (shadow_q[w]),
            .active_o (active_q[w])
        );

        if (w < N_L_REGS) begin : g_l
            assign reg_cfg_l_stream_sel_o[w*32 +: 32] = active_q[w];
        end else begin : g_s
            assign reg_cfg_s_stream_sel_o[(w-N_L_REGS)*32 +: 32] = active_q[w];
        end
    end

`ifdef CFG_LS_SEL_READBACK_EN
    // Select the addressed shadow word for readback.
    always_comb begin
        // NOTE: default assignment first so no path through the loop infers a latch.
        rd_word = '0;
        for (int w = 0; w < N_WORDS; w++) begin
            if (addr_i == ADDR_W'(w)) begin
                rd_word = shadow_q[w];
            end
        end
    end
`else
    logic unused_shadow;
    assign unused_shadow = ^shadow_q;
    assign rd_word       = '0;
`endif

    // Registered bus response, one cycle after each request.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= req_i;
            err_o    <= req_i & ~in_range;
            rdata_o  <= (req_i & ~we_i & in_range) ? rd_word : '0;
        end
    end

    // Commit FSM with registered pending flag and done pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q          <= IDLE;
            commit_pending_o <= 1'b0;
            commit_done_o    <= 1'b0;
        end else begin
            commit_done_o <= copy_en;
            case (state_q)
                IDLE: begin
                    if (commit_i && busy_i) begin
                        state_q          <= PENDING;
                        commit_pending_o <= 1'b1;
                    end
                end
                PENDING: begin
                    if (!busy_i) begin
                        state_q          <= IDLE;
                        commit_pending_o <= 1'b0;
                    end
                end
                default: begin
                    state_q          <= IDLE;
                    commit_pending_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_regs_ls_stream_sel_wr.sv
// Table-driven bench for cfg_regs_ls_stream_sel_wr with hand-written reset
// sequences around the vector table.
module tb_cfg_regs_ls_stream_sel_wr;
    import mage_pkg::*;

    localparam int NL = N_CFG_REGS_32_SEL_L_STREAM;
    localparam int NS = N_CFG_REGS_32_SEL_S_STREAM;
    localparam int AW = 3;
    localparam int NV = 19;

`ifdef CFG_LS_SEL_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            req, we, commit, busy;
    logic [AW-1:0]   addr;
    logic [31:0]     wdata;
    logic [3:0]      be;
    logic            gnt, rvalid, err, pending, done;
    logic [31:0]     rdata;
    logic [NL*32-1:0] lvec;
    logic [NS*32-1:0] svec;

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_miss = 0;

    cfg_regs_ls_stream_sel_wr dut (
        .clk_i                  (clk),
        .rst_n_i                (rst_n),
        .req_i                  (req),
        .we_i                   (we),
        .addr_i                 (addr),
        .wdata_i                (wdata),
        .be_i                   (be),
        .gnt_o                  (gnt),
        .rvalid_o               (rvalid),
        .rdata_o                (rdata),
        .err_o                  (err),
        .commit_i               (commit),
        .busy_i                 (busy),
        .commit_pending_o       (pending),
        .commit_done_o          (done),
        .reg_cfg_l_stream_sel_o (lvec),
        .reg_cfg_s_stream_sel_o (svec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        req, we;
        logic [AW-1:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        commit, busy;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err, pend, done;
        logic [NL*32-1:0] lvec;
        logic [NS*32-1:0] svec;
    } vec_t;

    vec_t tv [NV];

    function automatic vec_t mk(
        input logic r, w, input logic [AW-1:0] a, input logic [31:0] d,
        input logic [3:0] b, input logic c, bz,
        input logic erv, input logic [31:0] erd, input logic eer, epd, edn,
        input logic [NL*32-1:0] el, input logic [NS*32-1:0] es);
        vec_t v;
        v.req = r; v.we = w; v.addr = a; v.wdata = d; v.be = b;
        v.commit = c; v.busy = bz;
        v.rvalid = erv; v.rdata = erd; v.err = eer; v.pend = epd; v.done = edn;
        v.lvec = el; v.svec = es;
        return v;
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] x);
        return RB ? x : 32'h0;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, " rvalid"},  128'(rvalid),  128'(v.rvalid));
        check({tag, " rdata"},   128'(rdata),   128'(v.rdata));
        check({tag, " err"},     128'(err),     128'(v.err));
        check({tag, " pending"}, 128'(pending), 128'(v.pend));
        check({tag, " done"},    128'(done),    128'(v.done));
        check({tag, " lvec"},    128'(lvec),    128'(v.lvec));
        check({tag, " svec"},    128'(svec),    128'(v.svec));
    endtask

    task automatic drive(input vec_t v);
        req = v.req; we = v.we; addr = v.addr; wdata = v.wdata; be = v.be;
        commit = v.commit; busy = v.busy;
    endtask

    initial begin
        logic [NL*32-1:0] l1, l2;
        logic [NS*32-1:0] s1, s2;
        vec_t z;
        l1 = {96'h0, 32'hFFA5_FF34};
        l2 = {64'h0, 32'h0000_0001, 32'hFFA5_FF34};
        s1 = {32'h0, 32'h0000_0007};
        s2 = {32'h1234_0000, 32'h0000_0007};
        z  = mk(0,0,0,0,0,0,0, 0,0,0,0,0, '0,'0);

        //          req we a  wdata          be     c  b  | rv rdata                 er pd dn  l   s
        tv[0]  = mk(1, 1, 0, 32'hFFFF_FFFF, 4'hF,  0, 0,   1, 0,                    0, 0, 0, '0, '0);
        tv[1]  = mk(1, 1, 0, 32'hA5A5_1234, 4'h5,  0, 0,   1, 0,                    0, 0, 0, '0, '0);
        tv[2]  = mk(1, 0, 0, 32'h0,         4'h0,  0, 0,   1, rd(32'hFFA5_FF34),    0, 0, 0, '0, '0);
        tv[3]  = mk(0, 0, 0, 32'h0,         4'h0,  1, 0,   0, 0,                    0, 0, 1, l1, '0);
        tv[4]  = mk(0, 0, 0, 32'h0,         4'h0,  0, 0,   0, 0,                    0, 0, 0, l1, '0);
        tv[5]  = mk(0, 0, 0, 32'h0,         4'h0,  1, 1,   0, 0,                    0, 1, 0, l1, '0);
        tv[6]  = mk(1, 1, 4, 32'h0000_0007, 4'hF,  0, 1,   1, 0,                    0, 1, 0, l1, '0);
        tv[7]  = mk(0, 0, 0, 32'h0,         4'h0,  1, 1,   0, 0,                    0, 1, 0, l1, '0);
        tv[8]  = mk(1, 0, 4, 32'h0,         4'h0,  0, 1,   1, rd(32'h0000_0007),    0, 1, 0, l1, '0);
        tv[9]  = mk(0, 0, 0, 32'h0,         4'h0,  0, 1,   0, 0,                    0, 1, 0, l1, '0);
        tv[10] = mk(0, 0, 0, 32'h0,         4'h0,  0, 0,   0, 0,                    0, 0, 1, l1, s1);
        tv[11] = mk(0, 0, 0, 32'h0,         4'h0,  0, 0,   0, 0,                    0, 0, 0, l1, s1);
        tv[12] = mk(1, 1, 6, 32'hDEAD_BEEF, 4'hF,  0, 0,   1, 0,                    1, 0, 0, l1, s1);
        tv[13] = mk(1, 0, 7, 32'h0,         4'h0,  0, 0,   1, 0,                    1, 0, 0, l1, s1);
        tv[14] = mk(0, 0, 0, 32'h0,         4'h0,  1, 0,   0, 0,                    0, 0, 1, l1, s1);
        tv[15] = mk(1, 1, 1, 32'h0000_0001, 4'hF,  1, 0,   1, 0,                    0, 0, 1, l1, s1);
        tv[16] = mk(0, 0, 0, 32'h0,         4'h0,  1, 0,   0, 0,                    0, 0, 1, l2, s1);
        tv[17] = mk(1, 1, 5, 32'h1234_5678, 4'hC,  0, 0,   1, 0,                    0, 0, 0, l2, s1);
        tv[18] = mk(1, 0, 5, 32'h0,         4'h0,  1, 0,   1, rd(32'h1234_0000),    0, 0, 1, l2, s2);

        // Reset and post-reset state.
        drive(z);
        rst_n = 1'b0;
        #12;
        n_vec++;
        check_outputs("reset", z);
        @(negedge clk);
        rst_n = 1'b1;

        // Grant follows request combinationally.
        req = 1'b1; we = 1'b0;
        #1;
        n_vec++;
        check("gnt high", 128'(gnt), 128'(1'b1));
        req = 1'b0;
        #1;
        check("gnt low", 128'(gnt), 128'(1'b0));

        // Table-driven vectors: drive on the falling edge, sample after the rising edge.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tv[i]);
            @(posedge clk);
            #1;
            n_vec++;
            check_outputs($sformatf("vec%0d", i), tv[i]);
        end

        // Reset mid-operation: pending commit and in-flight write are dropped.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 3'd2; wdata = 32'hAAAA_5555; be = 4'hF;
        commit = 1'b1; busy = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        check("pre-reset pending", 128'(pending), 128'(1'b1));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        check_outputs("mid reset", z);
        @(negedge clk);
        drive(z);
        commit = 1'b1;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        check("post-reset commit done",    128'(done),    128'(1'b1));
        check("post-reset pending",        128'(pending), 128'(1'b0));
        check("post-reset lvec cleared",   128'(lvec),    128'(0));
        check("post-reset svec cleared",   128'(svec),    128'(0));
        @(negedge clk);
        drive(z);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
